// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunked add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Saturation bound for an n-bit signed result: most negative when sign=1,
  // most positive when sign=0. Returned zero-extended to 64 bits.
  function automatic logic [63:0] sat_bound(input int n, input logic sign);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < n - 1) r[i] = ~sign;
      else if (i == n - 1) r[i] = sign;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// W-bit ripple-carry adder that also exposes the carry into its top bit,
// so the final chunk of an operation yields the signed-overflow term.
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         c_msb_in,
  output logic         cout
);

  logic [W:0] c;

  // Bit-serial ripple through the chunk.
  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign c_msb_in = c[W-1];
  assign cout     = c[W];

endmodule

// File: rtl/chunked_addsub_unit.sv
// Multi-cycle two's-complement add/subtract unit. Operands are processed
// CHUNK bits per cycle through one narrow adder; the inter-chunk carry is
// held in a register. Flags and saturation are resolved on the last chunk.
//
// state  | meaning
// S_IDLE | ready for a new operation (in_ready=1)
// S_RUN  | adding chunk idx, one chunk per cycle
// S_DONE | result valid, held until out_ready
module chunked_addsub_unit
  import addsub_pkg::*;
#(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         ovf,
  output logic         cout,
  output logic         zero,
  output logic         neg
);

  localparam int NCHUNK = N / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q;
  logic           carry_q;
  logic [N-1:0]   a_q, b_q, res_q, s_q;
  logic           sat_q, ovf_q, cout_q, zero_q, neg_q;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             c_msb_in, c_out;
  logic             last_chunk, raw_ovf;
  logic [N-1:0]     res_next, final_s;
  logic [63:0]      bound;

  assign a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
  assign last_chunk = (idx_q == IW'(NCHUNK - 1));

  chunk_adder #(.W(CHUNK)) u_adder (
    .a        (a_chunk),
    .b        (b_chunk),
    .cin      (carry_q),
    .s        (sum_chunk),
    .c_msb_in (c_msb_in),
    .cout     (c_out)
  );

  // Merge the current chunk into the partial result and resolve saturation.
  always_comb begin
    res_next = res_q;
    res_next[idx_q*CHUNK +: CHUNK] = sum_chunk;
    raw_ovf  = c_msb_in ^ c_out;
    bound    = sat_bound(N, a_q[N-1]);
    final_s  = (sat_q && raw_ovf) ? bound[N-1:0] : res_next;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_RUN;
      end
      S_RUN: begin
        if (last_chunk) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, chunk accumulation and final flag/result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      res_q   <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {N{sub}};
            sat_q   <= sat;
            carry_q <= sub;
            idx_q   <= '0;
          end
        end
        S_RUN: begin
          res_q   <= res_next;
          carry_q <= c_out;
          idx_q   <= idx_q + 1'b1;
          if (last_chunk) begin
            s_q    <= final_s;
            ovf_q  <= raw_ovf;
            cout_q <= c_out;
            zero_q <= (final_s == '0);
            neg_q  <= final_s[N-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = s_q;
  assign ovf  = ovf_q;
  assign cout = cout_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule
